// File: rtl/ex_muldiv.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers for the EX stage.
// Holds the front of the pipeline while MULT/MULTU/DIV/DIVU iterate.
module ex_muldiv (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        valid_i,
    input  logic [5:0]  funct_i,
    input  logic [31:0] Data1_i,
    input  logic [31:0] Data2_i,
    output logic        stall_o,
    output logic        busy_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [4:0]  r_count;
    logic [63:0] r_acc;
    logic [31:0] r_opnd;
    logic [31:0] r_d1;
    logic        r_is_mul;
    logic        r_signed;
    logic        r_s1;
    logic        r_s2;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_is_md;
    logic        w_start;
    logic        w_is_mul;
    logic        w_signed;
    logic        w_s1;
    logic        w_s2;
    logic [31:0] w_mag1;
    logic [31:0] w_mag2;
    logic [32:0] w_sum;
    logic [63:0] w_mul_nxt;
    logic [32:0] w_rsh;
    logic [32:0] w_diff;
    logic [63:0] w_div_nxt;
    logic [63:0] w_prod;
    logic [31:0] w_fix_hi;
    logic [31:0] w_fix_lo;

    // Decode the incoming instruction and form operand magnitudes
    always_comb begin
        w_is_md  = valid_i & ((funct_i == F_MULT) | (funct_i == F_MULTU) |
                              (funct_i == F_DIV)  | (funct_i == F_DIVU));
        // Reset gating keeps stall low while the unit is held in reset
        w_start  = rst_n_i & w_is_md & (r_state == S_IDLE);
        w_is_mul = ~funct_i[1];
        w_signed = ~funct_i[0];
        w_s1     = w_signed & Data1_i[31];
        w_s2     = w_signed & Data2_i[31];
        w_mag1   = w_s1 ? (32'd0 - Data1_i) : Data1_i;
        w_mag2   = w_s2 ? (32'd0 - Data2_i) : Data2_i;
    end

    // One shift-add or restoring shift-subtract step on the accumulator
    always_comb begin
        w_sum     = {1'b0, r_acc[63:32]} +
                    (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
        w_mul_nxt = {w_sum, r_acc[31:1]};
        w_rsh     = {r_acc[63:32], r_acc[31]};
        w_diff    = w_rsh - {1'b0, r_opnd};
        if (w_diff[32])
            w_div_nxt = {w_rsh[31:0], r_acc[30:0], 1'b0};
        else
            w_div_nxt = {w_diff[31:0], r_acc[30:0], 1'b1};
    end

    // Sign correction and result placement applied in FIX
    always_comb begin
        w_prod   = (r_signed & (r_s1 ^ r_s2)) ? (64'd0 - r_acc) : r_acc;
        w_fix_hi = r_acc[63:32];
        w_fix_lo = r_acc[31:0];
        if (r_is_mul) begin
            w_fix_hi = w_prod[63:32];
            w_fix_lo = w_prod[31:0];
        end else if (r_opnd == 32'd0) begin
            w_fix_hi = r_d1;
            w_fix_lo = 32'hFFFF_FFFF;
        end else begin
            if (r_signed & (r_s1 ^ r_s2))
                w_fix_lo = 32'd0 - r_acc[31:0];
            if (r_signed & r_s1)
                w_fix_hi = 32'd0 - r_acc[63:32];
        end
    end

    // Control FSM, iteration datapath and HI/LO registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state  <= S_IDLE;
            r_count  <= 5'd0;
            r_acc    <= 64'd0;
            r_opnd   <= 32'd0;
            r_d1     <= 32'd0;
            r_is_mul <= 1'b0;
            r_signed <= 1'b0;
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state  <= S_RUN;
                        r_count  <= 5'd0;
                        r_is_mul <= w_is_mul;
                        r_signed <= w_signed;
                        r_s1     <= w_s1;
                        r_s2     <= w_s2;
                        r_d1     <= Data1_i;
                        // Mult: multiplier in low half, multiplicand added.
                        // Div: dividend in low half, divisor subtracted.
                        r_opnd   <= w_is_mul ? w_mag1 : w_mag2;
                        r_acc    <= {32'd0, w_is_mul ? w_mag2 : w_mag1};
                    end else if (valid_i && funct_i == F_MTHI) begin
                        r_hi <= Data1_i;
                    end else if (valid_i && funct_i == F_MTLO) begin
                        r_lo <= Data1_i;
                    end
                end
                S_RUN: begin
                    r_acc   <= r_is_mul ? w_mul_nxt : w_div_nxt;
                    r_count <= r_count + 5'd1;
                    if (r_count == 5'd31)
                        r_state <= S_FIX;
                end
                S_FIX: begin
                    r_hi    <= w_fix_hi;
                    r_lo    <= w_fix_lo;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o  = (r_state == S_RUN) | (r_state == S_FIX);
    assign stall_o = w_start | busy_o;
    assign hi_o    = r_hi;
    assign lo_o    = r_lo;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: directed mul/div/MTxx vectors,
// stall/busy timing, back-to-back ops and asynchronous reset abort.
module tb_ex_muldiv;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        valid_i;
    logic [5:0]  funct_i;
    logic [31:0] Data1_i;
    logic [31:0] Data2_i;
    logic        stall_o;
    logic        busy_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] sb_q[$];
    logic        prev_busy = 1'b0;

    ex_muldiv dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .valid_i (valid_i),
        .funct_i (funct_i),
        .Data1_i (Data1_i),
        .Data2_i (Data2_i),
        .stall_o (stall_o),
        .busy_o  (busy_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: an op has completed when busy drops; compare against scoreboard
    always @(negedge clk_i or negedge rst_n_i) begin
        logic [63:0] e;
        if (!rst_n_i) begin
            prev_busy <= 1'b0;
        end else begin
            if (prev_busy && !busy_o) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got hi=%h lo=%h expected none",
                             hi_o, lo_o);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_hi", hi_o, e[63:32]);
                    check("sb_lo", lo_o, e[31:0]);
                end
            end
            prev_busy <= busy_o;
        end
    end

    // Issue one mul/div op at posedge+1 and hold it through DONE
    task automatic op(input logic [5:0] f, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] eh,
                      input logic [31:0] el, output int st);
        int bad;
        st  = 0;
        bad = 0;
        sb_q.push_back({eh, el});
        valid_i = 1'b1;
        funct_i = f;
        Data1_i = a;
        Data2_i = b;
        for (int k = 0; k < 35; k++) begin
            @(negedge clk_i);
            if (stall_o) st++;
            if (stall_o !== (k <= 33)) bad++;
            if (busy_o !== (k >= 1 && k <= 33)) bad++;
            @(posedge clk_i);
            #1;
        end
        check("stall_cycles", st, 34);
        check("stall_busy_shape", bad, 0);
        valid_i = 1'b0;
    endtask

    task automatic mtxx(input logic [5:0] f, input logic [31:0] d);
        valid_i = 1'b1;
        funct_i = f;
        Data1_i = d;
        @(negedge clk_i);
        check("mtxx_stall", stall_o, 1'b0);
        check("mtxx_busy", busy_o, 1'b0);
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
    endtask

    initial begin
        int st1;
        int st2;
        rst_n_i = 1'b0;
        valid_i = 1'b0;
        funct_i = 6'h00;
        Data1_i = 32'd0;
        Data2_i = 32'd0;
        #12;
        check("rst_stall", stall_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_hi", hi_o, 32'd0);
        check("rst_lo", lo_o, 32'd0);
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;

        op(6'h18, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, st1);
        op(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, st1);
        op(6'h18, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, st1);
        op(6'h1A, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, st1);
        op(6'h1B, 32'h7, 32'h0, 32'h7, 32'hFFFF_FFFF, st1);
        op(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, st1);
        op(6'h1A, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, st1);

        op(6'h1B, 32'd100, 32'd7, 32'd2, 32'd14, st1);
        mtxx(6'h11, 32'h0000_1234);
        check("mthi_hi", hi_o, 32'h0000_1234);
        check("mthi_lo_kept", lo_o, 32'd14);
        mtxx(6'h13, 32'h0000_CAFE);
        check("mtlo_lo", lo_o, 32'h0000_CAFE);
        check("mtlo_hi_kept", hi_o, 32'h0000_1234);

        op(6'h19, 32'd3, 32'd5, 32'd0, 32'd15, st1);
        op(6'h1B, 32'd100, 32'd7, 32'd2, 32'd14, st2);
        check("b2b_total_stall", st1 + st2, 68);

        valid_i = 1'b1;
        funct_i = 6'h18;
        Data1_i = 32'h1234_5678;
        Data2_i = 32'h9;
        repeat (10) begin
            @(posedge clk_i);
            #1;
        end
        check("pre_rst_busy", busy_o, 1'b1);
        #2;
        rst_n_i = 1'b0;
        #1;
        check("arst_stall", stall_o, 1'b0);
        check("arst_busy", busy_o, 1'b0);
        check("arst_hi", hi_o, 32'd0);
        check("arst_lo", lo_o, 32'd0);
        valid_i = 1'b0;
        #1;
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        op(6'h19, 32'd6, 32'd7, 32'd0, 32'd42, st1);

        repeat (3) @(posedge clk_i);
        #1;
        check("sb_drained", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative 32-bit multiply/divide unit with HI/LO registers, sitting in the EX stage as the consumer of the ID/EX pipeline register outputs (operands, funct, valid). MULT/MULTU/DIV/DIVU run over multiple cycles. While they run, the unit holds the front of the pipeline with a stall signal, then releases the instruction for exactly one cycle so it retires. MTHI/MTLO write in a single cycle, and HI/LO are exposed for MFHI/MFLO forwarding into the EX result mux.

## Interface
- (no parameters) — datapath fixed at 32 bits, iteration count fixed at 32
- clk_i  in  1  clock, all state on rising edge
- rst_n_i  in  1  asynchronous, active-low reset
- valid_i  in  1  EX stage holds a valid R-type instruction (from ID/EX)
- funct_i  in  6  R-type funct field from ID/EX
- Data1_i  in  32  rs operand (forwarded value); dividend / multiplicand
- Data2_i  in  32  rt operand (forwarded value); divisor / multiplier
- stall_o  out  1  freeze PC, IF/ID and ID/EX; insert bubble into EX/MEM
- busy_o  out  1  iteration in progress (state RUN or FIX)
- hi_o  out  32  HI register
- lo_o  out  32  LO register

## Operation
- Decoded functs: MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MTHI 0x11, MTLO 0x13. All others are ignored. MFHI 0x10 and MFLO 0x12 need no action; the EX mux reads hi_o/lo_o.
- start = valid_i & funct in {0x18..0x1B} & state==IDLE.
- States:
  - IDLE: on start, latch operands and signs, count=0, go to RUN. On MTHI/MTLO, write Data1_i to HI/LO at the clock edge.
  - RUN: one shift-add (mult) or restoring shift-subtract (div) step per cycle on operand magnitudes. Go to FIX when count==31.
  - FIX: apply sign correction and write HI/LO; go to DONE.
  - DONE: one cycle, stall_o=0, valid_i/funct_i ignored (the stalled instruction is still presented and must not restart); go to IDLE.
- stall_o = start | (state==RUN) | (state==FIX). busy_o = (state==RUN)|(state==FIX).
- Signed ops operate on magnitudes. Product sign = s1^s2. Quotient sign = s1^s2. Remainder sign = dividend sign. Unsigned ops skip correction.
- Result placement: mult puts the 64-bit product in {HI,LO}. Div puts quotient in LO and remainder in HI.
- Divide by zero (signed or unsigned): LO=0xFFFFFFFF, HI=Data1 as latched. No exception.
- DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (wraps, no trap).
- MTHI/MTLO presented in any state other than IDLE are ignored; the pipeline cannot present them then.

## Timing
- Reset (async, immediate): state=IDLE, count=0, HI=LO=0, all internal operand regs 0, stall_o=0, busy_o=0.
- Reset asserted mid-operation aborts the operation with no HI/LO update beyond clearing to 0. The first start after deassertion behaves normally.
- Op latency, with start seen in cycle 0 (stall_o high combinationally):
  - RUN occupies cycles 1–32.
  - FIX occupies cycle 33; HI/LO update at the end of this cycle.
  - DONE is cycle 34; stall_o=0 and hi_o/lo_o hold the final result.
  - IDLE resumes from cycle 35.
  - stall_o is high for exactly 34 consecutive cycles (0–33).
- An MFHI/MFLO immediately following a mul/div enters EX in cycle 35 and sees the new HI/LO; no extra interlock is needed.
- MTHI/MTLO: stall_o stays 0, and hi_o/lo_o show the new value the cycle after the edge.
- Back-to-back mul/div: the second op enters EX at cycle 35, and start is allowed in that cycle.

## Test plan
- MULT 0xFFFFFFFE × 0x00000003 → HI=0xFFFFFFFF, LO=0xFFFFFFFA. stall_o high exactly 34 cycles; busy_o high cycles 1–33.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. MULT 0x80000000 × 0x80000000 → HI=0x40000000, LO=0.
- DIV 0xFFFFFFF9 (−7) / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7 / 0 → LO=0xFFFFFFFF, HI=7. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- valid_i=1 with DIVU held constant through DONE → exactly one operation; state returns to IDLE with stall_o=0. Then MTHI 0x00001234 → hi_o=0x00001234 next cycle, stall_o never asserted.
- Back-to-back MULTU 3×5 then DIVU 100/7 with the second start in cycle 35 → after the first op HI=0, LO=15; after the second HI=2, LO=14. Total stall 68 cycles.
- rst_n_i pulsed low during cycle 10 of a MULT → stall_o, busy_o, hi_o, lo_o go to 0 immediately, without waiting for a clock edge. A subsequent MULTU 6×7 gives LO=42, HI=0.
